// File: rtl/voice_scaler_scheduler.sv
// voice_scaler_scheduler: shares one amplitude downscaler across NUM_VOICES voices
// and mixes the scaled results into one midpoint-offset unsigned sample.
`default_nettype none

module voice_scaler_scheduler #(
   parameter int NUM_VOICES     = 4,
   parameter int DATA_BITS      = 12,
   parameter int AMPLITUDE_BITS = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 sample_tick,
   input  logic [NUM_VOICES*DATA_BITS-1:0]      voice_din,
   input  logic [NUM_VOICES*AMPLITUDE_BITS-1:0] voice_amp,
   input  logic [NUM_VOICES-1:0]                voice_en,
   input  logic                                 overrun_clr,
   output logic [DATA_BITS-1:0]                 sc_din,
   output logic [AMPLITUDE_BITS-1:0]            sc_amplitude,
   input  logic [DATA_BITS-1:0]                 sc_dout,
   output logic [DATA_BITS-1:0]                 mix_out,
   output logic                                 mix_valid,
   output logic                                 busy,
   output logic                                 overrun
);

   localparam int IDX_BITS = $clog2(NUM_VOICES);
   localparam int ACC_BITS = DATA_BITS + IDX_BITS;
   localparam logic [DATA_BITS-1:0] MIDPOINT = {1'b1, {(DATA_BITS-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, DRIVE, ACCUM, DONE} state_t;

   state_t                              state, state_nxt;
   logic [IDX_BITS-1:0]                 idx;
   logic signed [ACC_BITS-1:0]          acc;
   logic [NUM_VOICES*DATA_BITS-1:0]     shadow_din;
   logic [NUM_VOICES*AMPLITUDE_BITS-1:0] shadow_amp;
   logic [NUM_VOICES-1:0]               shadow_en;

   logic                                last_voice;
   logic signed [DATA_BITS-1:0]         deviation;
   logic signed [DATA_BITS-1:0]         acc_shift;

   assign last_voice = (idx == IDX_BITS'(NUM_VOICES-1));
   // Subtracting the midpoint from an offset-binary value is just an MSB flip.
   assign deviation  = {~sc_dout[DATA_BITS-1], sc_dout[DATA_BITS-2:0]};
   assign acc_shift  = DATA_BITS'(acc >>> IDX_BITS);
   assign busy       = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sample_tick) state_nxt = DRIVE;
         DRIVE:   state_nxt = ACCUM;
         ACCUM:   state_nxt = last_voice ? DONE : DRIVE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx          <= '0;
         acc          <= '0;
         shadow_din   <= '0;
         shadow_amp   <= '0;
         shadow_en    <= '0;
         sc_din       <= '0;
         sc_amplitude <= '0;
         mix_out      <= MIDPOINT;
         mix_valid    <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         mix_valid <= 1'b0;

         // A busy tick setting the flag takes priority over a clear.
         if (sample_tick && busy)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;

         case (state)
            IDLE: begin
               if (sample_tick) begin
                  shadow_din <= voice_din;
                  shadow_amp <= voice_amp;
                  shadow_en  <= voice_en;
                  acc        <= '0;
                  idx        <= '0;
               end
            end
            DRIVE: begin
               sc_din       <= shadow_din[idx*DATA_BITS +: DATA_BITS];
               sc_amplitude <= shadow_amp[idx*AMPLITUDE_BITS +: AMPLITUDE_BITS];
            end
            ACCUM: begin
               if (shadow_en[idx])
                  acc <= acc + {{IDX_BITS{deviation[DATA_BITS-1]}}, deviation};
               if (!last_voice)
                  idx <= idx + 1'b1;
            end
            DONE: begin
               mix_out   <= acc_shift ^ MIDPOINT;
               mix_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
